// File: rtl/alu_ops_pkg.sv
// Shared ALU control codes, MIPS opcode/funct constants and the decoded-entry
// record that travels from ID into the EX pipeline register.
package alu_ops_pkg;

    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_SLT = 5'b00111;
    localparam logic [4:0] ALU_NOR = 5'b01100;
    localparam logic [4:0] ALU_XOR = 5'b01101;
    localparam logic [4:0] ALU_SLL = 5'b10000;
    localparam logic [4:0] ALU_SRL = 5'b11000;
    localparam logic [4:0] ALU_SRA = 5'b11001;
    localparam logic [4:0] ALU_ILL = 5'b11111;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        logic [4:0]  ct;
        logic        sign;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  wr_reg;
        logic        reg_write;
        logic        illegal;
    } decode_t;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [31:0] zext16(input logic [15:0] imm);
        return {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of a MIPS instruction word into ALU control, signedness,
// operand selection and writeback information.
module alu_decode
    import alu_ops_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [4:0]  ct,
    output logic        sign,
    output logic [31:0] in1,
    output logic [31:0] in2,
    output logic [4:0]  wr_reg,
    output logic        reg_write,
    output logic        illegal
);

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic        write_en;
    logic        unused_rs_field;

    assign op       = instr[31:26];
    assign rt_field = instr[20:16];
    assign rd_field = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];

    // The rs register number is resolved upstream; only its forwarded data is used here.
    assign unused_rs_field = ^instr[25:21];

    always_comb begin
        ct       = ALU_ILL;
        sign     = 1'b0;
        in1      = rs;
        in2      = rt;
        wr_reg   = rt_field;
        write_en = 1'b1;
        illegal  = 1'b0;

        case (op)
            OP_RTYPE: begin
                wr_reg = rd_field;
                case (funct)
                    FN_ADD:  begin ct = ALU_ADD; sign = 1'b1; end
                    FN_ADDU: ct = ALU_ADD;
                    FN_SUB:  begin ct = ALU_SUB; sign = 1'b1; end
                    FN_SUBU: ct = ALU_SUB;
                    FN_AND:  ct = ALU_AND;
                    FN_OR:   ct = ALU_OR;
                    FN_XOR:  ct = ALU_XOR;
                    FN_NOR:  ct = ALU_NOR;
                    FN_SLT:  begin ct = ALU_SLT; sign = 1'b1; end
                    FN_SLTU: ct = ALU_SLT;
                    FN_SLLV: ct = ALU_SLL;
                    FN_SRLV: ct = ALU_SRL;
                    FN_SRAV: ct = ALU_SRA;
                    FN_SLL:  begin ct = ALU_SLL; in1 = {27'b0, shamt}; end
                    FN_SRL:  begin ct = ALU_SRL; in1 = {27'b0, shamt}; end
                    FN_SRA:  begin ct = ALU_SRA; in1 = {27'b0, shamt}; end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin ct = ALU_ADD; sign = 1'b1; in2 = sext16(imm); end
            OP_ADDIU: begin ct = ALU_ADD; in2 = sext16(imm); end
            OP_SLTI:  begin ct = ALU_SLT; sign = 1'b1; in2 = sext16(imm); end
            OP_SLTIU: begin ct = ALU_SLT; in2 = sext16(imm); end
            OP_ANDI:  begin ct = ALU_AND; in2 = zext16(imm); end
            OP_ORI:   begin ct = ALU_OR;  in2 = zext16(imm); end
            OP_XORI:  begin ct = ALU_XOR; in2 = zext16(imm); end
            // LUI is executed as the immediate shifted left by a constant 16.
            OP_LUI:   begin ct = ALU_SLL; in1 = 32'd16; in2 = zext16(imm); end
            OP_LW:    begin ct = ALU_ADD; in2 = sext16(imm); end
            OP_SW:    begin ct = ALU_ADD; in2 = sext16(imm); write_en = 1'b0; end
            OP_BEQ,
            OP_BNE:   begin ct = ALU_SUB; write_en = 1'b0; end
            default:  illegal = 1'b1;
        endcase

        if (illegal) begin
            ct       = ALU_ILL;
            sign     = 1'b0;
            in1      = 32'd0;
            in2      = 32'd0;
            wr_reg   = 5'd0;
            write_en = 1'b0;
        end
    end

    // Writes to $0 are architecturally discarded, so never request them.
    assign reg_write = write_en && (wr_reg != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes the instruction and holds it in a valid/ready
// pipeline register with flush, plus a saturating illegal-instruction counter.
module alu_issue_stage
    import alu_ops_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    output logic             id_ready,
    input  logic [31:0]      id_instr,
    input  logic [31:0]      id_rs_data,
    input  logic [31:0]      id_rt_data,
    input  logic             flush,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [4:0]       ex_alu_ct,
    output logic             ex_sign,
    output logic [31:0]      ex_in1,
    output logic [31:0]      ex_in2,
    output logic [4:0]       ex_wr_reg,
    output logic             ex_reg_write,
    output logic             ex_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [4:0]  dec_ct;
    logic        dec_sign;
    logic [31:0] dec_in1;
    logic [31:0] dec_in2;
    logic [4:0]  dec_wr_reg;
    logic        dec_reg_write;
    logic        dec_illegal;
    decode_t     dec;
    decode_t     ex_q;
    logic        accept;

    alu_decode u_decode (
        .instr     (id_instr),
        .rs        (id_rs_data),
        .rt        (id_rt_data),
        .ct        (dec_ct),
        .sign      (dec_sign),
        .in1       (dec_in1),
        .in2       (dec_in2),
        .wr_reg    (dec_wr_reg),
        .reg_write (dec_reg_write),
        .illegal   (dec_illegal)
    );

    assign dec = '{ct: dec_ct, sign: dec_sign, in1: dec_in1, in2: dec_in2,
                   wr_reg: dec_wr_reg, reg_write: dec_reg_write, illegal: dec_illegal};

    // Ready depends only on the register state, never on id_valid.
    assign id_ready = !ex_valid || ex_ready;
    assign accept   = id_valid && id_ready && !flush;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

    // Payload only loads on accept so it stays stable while back-pressured.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= '0;
        end else if (accept) begin
            ex_q <= dec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_cnt <= '0;
        end else if (accept && dec_illegal && (illegal_cnt != '1)) begin
            illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    assign ex_alu_ct    = ex_q.ct;
    assign ex_sign      = ex_q.sign;
    assign ex_in1       = ex_q.in1;
    assign ex_in2       = ex_q.in2;
    assign ex_wr_reg    = ex_q.wr_reg;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_illegal   = ex_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: the driver pushes expected entries on
// accept, a negedge monitor pops and compares whenever EX takes an entry.
module tb_alu_issue_stage;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic             id_ready;
    logic [31:0]      id_instr;
    logic [31:0]      id_rs_data;
    logic [31:0]      id_rt_data;
    logic             flush;
    logic             ex_valid;
    logic             ex_ready;
    logic [4:0]       ex_alu_ct;
    logic             ex_sign;
    logic [31:0]      ex_in1;
    logic [31:0]      ex_in2;
    logic [4:0]       ex_wr_reg;
    logic             ex_reg_write;
    logic             ex_illegal;
    logic [CNT_W-1:0] illegal_cnt;

    logic ready_val;
    logic rand_ready;
    logic rnd_ready = 1'b1;

    assign ex_ready = rand_ready ? rnd_ready : ready_val;

    alu_issue_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_instr     (id_instr),
        .id_rs_data   (id_rs_data),
        .id_rt_data   (id_rt_data),
        .flush        (flush),
        .ex_valid     (ex_valid),
        .ex_ready     (ex_ready),
        .ex_alu_ct    (ex_alu_ct),
        .ex_sign      (ex_sign),
        .ex_in1       (ex_in1),
        .ex_in2       (ex_in2),
        .ex_wr_reg    (ex_wr_reg),
        .ex_reg_write (ex_reg_write),
        .ex_illegal   (ex_illegal),
        .illegal_cnt  (illegal_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    typedef struct {
        logic [4:0]  ct;
        logic        sign;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [4:0]  wr;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t none;
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;
    int   model_cnt = 0;
    int   rst_req = 0;
    int   rst_done = 0;
    bit   end_req = 0;
    bit   end_done = 0;

    logic [5:0] r_fn [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B, 6'h04, 6'h06, 6'h07, 6'h00, 6'h02, 6'h03};
    logic [5:0] i_op [13] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                              6'h23, 6'h2B, 6'h04, 6'h05, 6'h3F};

    function automatic exp_t mk(input logic [4:0] ct, input logic sign, input logic [31:0] in1,
                                input logic [31:0] in2, input logic [4:0] wr, input logic rw,
                                input logic ill);
        exp_t e;
        e.ct = ct; e.sign = sign; e.in1 = in1; e.in2 = in2; e.wr = wr; e.rw = rw; e.ill = ill;
        return e;
    endfunction

    // Reference model: the instruction table written out mnemonic by mnemonic.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
        exp_t        e;
        bit          ok = 1'b1;
        logic [5:0]  op = ins[31:26];
        logic [5:0]  fn = ins[5:0];
        logic [15:0] imm = ins[15:0];
        logic [31:0] sx = 32'($signed(imm));
        logic [31:0] zx = 32'(imm);
        logic [31:0] sh = 32'(ins[10:6]);
        e = mk(5'b00000, 1'b0, rs, rt, ins[20:16], 1'b1, 1'b0);
        if (op == 6'h00) begin
            e.wr = ins[15:11];
            case (fn)
                6'h20: begin e.ct = 5'b00010; e.sign = 1'b1; end
                6'h21: e.ct = 5'b00010;
                6'h22: begin e.ct = 5'b00110; e.sign = 1'b1; end
                6'h23: e.ct = 5'b00110;
                6'h24: e.ct = 5'b00000;
                6'h25: e.ct = 5'b00001;
                6'h26: e.ct = 5'b01101;
                6'h27: e.ct = 5'b01100;
                6'h2A: begin e.ct = 5'b00111; e.sign = 1'b1; end
                6'h2B: e.ct = 5'b00111;
                6'h04: e.ct = 5'b10000;
                6'h06: e.ct = 5'b11000;
                6'h07: e.ct = 5'b11001;
                6'h00: begin e.ct = 5'b10000; e.in1 = sh; end
                6'h02: begin e.ct = 5'b11000; e.in1 = sh; end
                6'h03: begin e.ct = 5'b11001; e.in1 = sh; end
                default: ok = 1'b0;
            endcase
        end else begin
            case (op)
                6'h08: begin e.ct = 5'b00010; e.sign = 1'b1; e.in2 = sx; end
                6'h09: begin e.ct = 5'b00010; e.in2 = sx; end
                6'h0A: begin e.ct = 5'b00111; e.sign = 1'b1; e.in2 = sx; end
                6'h0B: begin e.ct = 5'b00111; e.in2 = sx; end
                6'h0C: begin e.ct = 5'b00000; e.in2 = zx; end
                6'h0D: begin e.ct = 5'b00001; e.in2 = zx; end
                6'h0E: begin e.ct = 5'b01101; e.in2 = zx; end
                6'h0F: begin e.ct = 5'b10000; e.in1 = 32'd16; e.in2 = zx; end
                6'h23: begin e.ct = 5'b00010; e.in2 = sx; end
                6'h2B: begin e.ct = 5'b00010; e.in2 = sx; e.rw = 1'b0; end
                6'h04, 6'h05: begin e.ct = 5'b00110; e.rw = 1'b0; end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) e = mk(5'b11111, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
        if (e.wr == 5'd0) e.rw = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom();
        int k = $urandom_range(0, 9);
        if (k < 4) begin
            w[31:26] = 6'h00;
            w[5:0]   = r_fn[$urandom_range(0, 15)];
        end else if (k < 8) begin
            w[31:26] = i_op[$urandom_range(0, 12)];
        end
        return w;
    endfunction

    function automatic logic [31:0] rand_data();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'd0;
            default: return $urandom();
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one compare pass per cycle, mid-cycle, decoupled from the driver.
    always @(negedge clk) begin
        if (reset) begin
            q.delete();
        end else begin
            checkOutput("ex_valid", 32'(ex_valid), 32'(q.size() != 0));
            checkOutput("id_ready", 32'(id_ready), 32'((q.size() == 0) || ex_ready));
            checkOutput("illegal_cnt", 32'(illegal_cnt), 32'(model_cnt));
            if (ex_valid && (q.size() != 0)) begin
                mon_e = q[0];
                checkOutput("ex_alu_ct", 32'(ex_alu_ct), 32'(mon_e.ct));
                checkOutput("ex_sign", 32'(ex_sign), 32'(mon_e.sign));
                checkOutput("ex_in1", ex_in1, mon_e.in1);
                checkOutput("ex_in2", ex_in2, mon_e.in2);
                checkOutput("ex_wr_reg", 32'(ex_wr_reg), 32'(mon_e.wr));
                checkOutput("ex_reg_write", 32'(ex_reg_write), 32'(mon_e.rw));
                checkOutput("ex_illegal", 32'(ex_illegal), 32'(mon_e.ill));
                if (ex_ready) void'(q.pop_front());
            end
            if (flush) q.delete();
            if (rst_req != rst_done) begin
                checkOutput("rst_ex_valid", 32'(ex_valid), 32'd0);
                checkOutput("rst_id_ready", 32'(id_ready), 32'd1);
                checkOutput("rst_ex_alu_ct", 32'(ex_alu_ct), 32'd0);
                checkOutput("rst_ex_sign", 32'(ex_sign), 32'd0);
                checkOutput("rst_ex_in1", ex_in1, 32'd0);
                checkOutput("rst_ex_in2", ex_in2, 32'd0);
                checkOutput("rst_ex_wr_reg", 32'(ex_wr_reg), 32'd0);
                checkOutput("rst_ex_reg_write", 32'(ex_reg_write), 32'd0);
                checkOutput("rst_ex_illegal", 32'(ex_illegal), 32'd0);
                checkOutput("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);
                rst_done = rst_req;
            end
            if (end_req && !end_done) begin
                checkOutput("drain_pending", 32'(q.size()), 32'd0);
                checkOutput("final_illegal_cnt", 32'(illegal_cnt), 32'd255);
                end_done = 1'b1;
            end
        end
    end

    // Holds one instruction on ID until accepted; expected entry pushed on accept.
    task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                 input bit gold_en, input exp_t gold);
        exp_t m;
        bit   acc;
        id_valid   = 1'b1;
        id_instr   = ins;
        id_rs_data = a;
        id_rt_data = b;
        flush      = 1'b0;
        m = model(ins, a, b);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            #1;
            acc = id_ready && !flush;
            if (acc) begin
                q.push_back(gold_en ? gold : m);
                if (m.ill && (model_cnt < 255)) model_cnt++;
            end
            @(posedge clk);
            #1;
            if (acc) begin
                id_valid = 1'b0;
                return;
            end
        end
        $display("[TB] FAIL accept_timeout: id_ready stayed 0 for 64 cycles, required 1");
        $fatal(1, "[TB] stage never accepted");
    endtask

    task automatic applyFlush(input logic [31:0] ins);
        id_valid   = 1'b1;
        id_instr   = ins;
        id_rs_data = rand_data();
        id_rt_data = rand_data();
        flush      = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        id_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        id_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic resetDut();
        reset     = 1'b1;
        id_valid  = 1'b0;
        flush     = 1'b0;
        model_cnt = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        rst_req++;
    endtask

    initial begin
        reset      = 1'b1;
        id_valid   = 1'b0;
        id_instr   = 32'd0;
        id_rs_data = 32'd0;
        id_rt_data = 32'd0;
        flush      = 1'b0;
        ready_val  = 1'b1;
        rand_ready = 1'b0;
        none       = mk(5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

        resetDut();

        // Directed encodings with hand-derived expectations.
        applyStimulus(32'h0022_1820, 32'd5, 32'd7, 1,
                      mk(5'b00010, 1'b1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
        applyStimulus(32'h3C04_1234, 32'h0000_DEAD, 32'd1, 1,
                      mk(5'b10000, 1'b0, 32'd16, 32'h0000_1234, 5'd4, 1'b1, 1'b0));
        applyStimulus(32'h24C5_FFFF, 32'd10, 32'd2, 1,
                      mk(5'b00010, 1'b0, 32'd10, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0));
        applyStimulus(32'h3107_FFFF, 32'h1234_5678, 32'd2, 1,
                      mk(5'b00000, 1'b0, 32'h1234_5678, 32'h0000_FFFF, 5'd7, 1'b1, 1'b0));
        applyStimulus(32'h0003_1103, 32'h5555_5555, 32'h8000_0000, 1,
                      mk(5'b11001, 1'b0, 32'd4, 32'h8000_0000, 5'd2, 1'b1, 1'b0));
        applyStimulus(32'h016A_4807, 32'h0000_0023, 32'hF000_0000, 1,
                      mk(5'b11001, 1'b0, 32'h0000_0023, 32'hF000_0000, 5'd9, 1'b1, 1'b0));
        applyStimulus(32'hFC22_1820, 32'd5, 32'd7, 1,
                      mk(5'b11111, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1));
        applyStimulus(32'hACC5_0008, 32'h0000_1000, 32'd9, 1,
                      mk(5'b00010, 1'b0, 32'h0000_1000, 32'd8, 5'd5, 1'b0, 1'b0));
        applyStimulus(32'h1022_0010, 32'd3, 32'd3, 1,
                      mk(5'b00110, 1'b0, 32'd3, 32'd3, 5'd2, 1'b0, 1'b0));
        applyStimulus(32'h0022_0021, 32'd1, 32'd2, 1,
                      mk(5'b00010, 1'b0, 32'd1, 32'd2, 5'd0, 1'b0, 1'b0));
        idle(2);

        // Back-pressure: one entry parked, a stream waits three cycles behind it.
        ready_val = 1'b0;
        applyStimulus(rand_instr(), rand_data(), rand_data(), 0, none);
        fork
            begin
                repeat (3) @(posedge clk);
                #3;
                ready_val = 1'b1;
            end
            begin
                for (int i = 0; i < 4; i++)
                    applyStimulus(rand_instr(), rand_data(), rand_data(), 0, none);
            end
        join
        idle(2);

        // Flush an illegal input while a held entry is present.
        ready_val = 1'b0;
        applyStimulus(32'h0022_1820, 32'd1, 32'd1, 0, none);
        applyFlush(32'hFC00_0000);
        idle(2);
        ready_val = 1'b1;

        // Randomised traffic with random EX readiness and occasional flushes.
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 15))
                0:       applyFlush(rand_instr());
                1:       idle(1);
                default: applyStimulus(rand_instr(), rand_data(), rand_data(), 0, none);
            endcase
        end
        rand_ready = 1'b0;
        ready_val  = 1'b1;
        idle(3);

        // Reset while an entry is held under back-pressure.
        ready_val = 1'b0;
        applyStimulus(32'h0022_1820, 32'd5, 32'd7, 0, none);
        idle(1);
        resetDut();
        ready_val = 1'b1;
        idle(2);

        // Counter saturation.
        for (int i = 0; i < 260; i++)
            applyStimulus({6'h3F, 26'($urandom())}, rand_data(), rand_data(), 0, none);
        idle(3);

        end_req = 1'b1;
        for (int i = 0; i < 20 && !end_done; i++) @(posedge clk);
        if (!end_done) begin
            $display("[TB] FAIL end_check: monitor did not complete, got 0 required 1");
            $fatal(1, "[TB] end check timed out");
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID→EX issue stage for the MIPS pipeline and the producer side of the ALU's `ALUCt`/`Sign`/`in1`/`in2` interface. It decodes the instruction word into the 5-bit ALU control code and signedness flag, and selects and extends operands, including shift amount and LUI handling. It registers the result in a valid/ready ID/EX pipeline register with flush support. It also flags illegal encodings and counts them.

## Interface
Parameters:
- `CNT_W`, 8, width of the saturating illegal-instruction counter.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `id_valid`  in  1  ID holds an instruction.
- `id_ready`  out  1  stage accepts this cycle.
- `id_instr`  in  32  instruction word.
- `id_rs_data`  in  32  rs operand (already forwarded).
- `id_rt_data`  in  32  rt operand (already forwarded).
- `flush`  in  1  kill register contents and current input.
- `ex_valid`  out  1  EX register holds an instruction.
- `ex_ready`  in  1  EX consumes this cycle.
- `ex_alu_ct`  out  5  ALU control code.
- `ex_sign`  out  1  signed compare select.
- `ex_in1`, `ex_in2`  out  32  ALU operands.
- `ex_wr_reg`  out  5  destination register.
- `ex_reg_write`  out  1  writeback enable.
- `ex_illegal`  out  1  entry was an illegal encoding.
- `illegal_cnt`  out  `CNT_W`  saturating count of illegal instructions accepted.

## Operation
- ALU codes: AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, NOR 01100, XOR 01101, SLL 10000, SRL 11000, SRA 11001, ILL 11111 (ALU returns 0).
- The ALU shifts `in2` by `in1[4:0]`.
- R-type (op 0x00), `in1=rs`, `in2=rt`, `wr=rd`:
  - add 0x20: ADD, sign 1.
  - addu 0x21: ADD, sign 0.
  - sub 0x22: SUB, sign 1.
  - subu 0x23: SUB, sign 0.
  - and 0x24, or 0x25, xor 0x26, nor 0x27: sign 0.
  - slt 0x2A: SLT, sign 1.
  - sltu 0x2B: SLT, sign 0.
  - sllv 0x04, srlv 0x06, srav 0x07: `in1=rs`.
  - sll 0x00, srl 0x02, sra 0x03: `in1={27'b0,shamt}`.
- I-type, `wr=rt`. sext/zext apply to `imm16`.
  - addi 0x08: ADD, sign 1, `in2` sext.
  - addiu 0x09: ADD, sign 0, sext.
  - slti 0x0A: SLT, sign 1, sext.
  - sltiu 0x0B: SLT, sign 0, sext.
  - andi 0x0C, ori 0x0D, xori 0x0E: zext.
  - lui 0x0F: SLL, `in1=32'd16`, `in2` zext.
  - lw 0x23: ADD, sext, write.
  - sw 0x2B: ADD, sext, no write.
  - beq 0x04 / bne 0x05: SUB, `in2=rt`, no write.
- `ex_reg_write=0` whenever `ex_wr_reg==0`.
- Illegal: any other op or funct. Outputs `ct=ILL`, `reg_write=0`, `ex_illegal=1`, operands 0.
- `illegal_cnt` increments on acceptance of an illegal instruction and saturates at all-ones.

## Timing
- Reset values:
  - `ex_valid=0`, `illegal_cnt=0`.
  - `ex_alu_ct=0`, `ex_sign=0`, `ex_in1=0`, `ex_in2=0`, `ex_wr_reg=0`, `ex_reg_write=0`, `ex_illegal=0`.
  - `id_ready=1` in the cycle after reset deasserts.
- `id_ready = !ex_valid || ex_ready`, combinational. There is no path from `id_valid` to `id_ready`.
- Accept = `id_valid && id_ready && !flush`. Decoded fields appear on `ex_*` the next cycle. Latency is 1 cycle and throughput is 1 per cycle.
- `ex_valid` next-state, in priority order:
  1. `flush` → 0, overriding accept and hold. A flushed input is not counted.
  2. Accept → 1.
  3. `ex_valid && ex_ready` → 0.
  4. Otherwise hold.
- While holding, all `ex_*` data outputs are stable.
- Back-pressure (`ex_valid=1`, `ex_ready=0`): `id_ready=0`, register unchanged, counter unchanged.
- Reset mid-operation (reset asserted while an instruction is held) discards the instruction and returns to the reset state. Reset dominates flush.
- Data fields may keep stale values when `ex_valid=0`. The bench checks them only when valid.

## Structure
- `alu_ops_pkg` holds:
  - ALU code localparams (`ALU_AND` … `ALU_SRA`, `ALU_ILL`).
  - Opcode constants.
  - R-type funct constants.
- Sub-module `alu_decode`, purely combinational: `instr`, `rs`, `rt` → `ct`, `sign`, `in1`, `in2`, `wr_reg`, `reg_write`, `illegal`.
- The top holds the pipeline register, handshake, and counter.

## Test plan
- **Reset:** reset 2 cycles → all outputs 0, `id_ready=1`. Send `add $3,$1,$2` (0x00221820), rs=5, rt=7 → next cycle `ct=00010`, `sign=1`, `in1=5`, `in2=7`, `wr=3`, `reg_write=1`.
- **Immediates:**
  - `lui $4,0x1234` → `ct=10000`, `in1=16`, `in2=0x00001234`, `wr=4`.
  - `addiu` with imm 0xFFFF → `in2=0xFFFFFFFF`, `sign=0`.
  - `andi` with imm 0xFFFF → `in2=0x0000FFFF`.
- **Shifts:**
  - `sra $2,$3,4` (0x00031103), rt=0x80000000 → `ct=11001`, `in1=4`, `in2=0x80000000`.
  - `srav` → `in1=rs`.
- **Back-pressure:** `ex_ready=0` for 3 cycles with a stream of instructions → `id_ready=0`, first instruction held stable. Raise `ex_ready` → each instruction appears once, in order.
- **Flush:** `flush` together with a valid input while `ex_valid=1` → next cycle `ex_valid=0`, `illegal_cnt` unchanged even if the input was illegal.
- **Illegal/no-write:**
  - op 0x3F → `ct=11111`, `ex_illegal=1`, `reg_write=0`, count +1.
  - 260 illegal instructions → count saturates at 255.
  - `sw`, `beq`, and writes to `$0` → `reg_write=0`.
